shift_piso_tx: RTL and testbench

- Parallel-in, serial-out transmitter for the 2-bit symbol shift path.
- Accepts a full word through a valid/ready handshake and emits it as NSYM consecutive SYM_W-bit symbols, least-significant symbol first, one per clock.
- A one-word holding buffer lets back-to-back words stream with no idle gap.
- Sits upstream of the 2-bit serial delay/deserialize chain.

---
 rtl/shift_piso_tx_if.sv | 27 ++
 rtl/shift_piso_tx.sv | 93 +++++++++
 tb/tb_shift_piso_tx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_piso_tx_if.sv
// Load handshake and serial symbol bus of the 2-bit PISO transmitter.
// The slave side is the transmitter; the master side feeds it words and watches the symbols.
interface shift_piso_tx_if #(
    parameter int SYM_W = 2,
    parameter int NSYM  = 4
);
    localparam int W = SYM_W * NSYM;

    logic [W-1:0]     load_data;
    logic             load_valid;
    logic             load_ready;
    logic [SYM_W-1:0] dataout;
    logic             sym_valid;
    logic             sof;
    logic             eof;
    logic             busy;

    modport master (
        output load_data, load_valid,
        input  load_ready, dataout, sym_valid, sof, eof, busy
    );

    modport slave (
        input  load_data, load_valid,
        output load_ready, dataout, sym_valid, sof, eof, busy
    );
endinterface

// File: rtl/shift_piso_tx.sv
// Parallel-in, serial-out transmitter: one word in, NSYM symbols out LS-symbol first,
// with a one-word holding buffer so consecutive words stream without a gap.
module shift_piso_tx #(
    parameter int SYM_W = 2,
    parameter int NSYM  = 4
) (
    input logic            clk,
    input logic            reset_n,
    shift_piso_tx_if.slave bus
);
    localparam int W  = SYM_W * NSYM;
    localparam int CW = $clog2(NSYM);
    localparam logic [CW-1:0] LAST = CW'(NSYM - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  sh, sh_nxt;
    logic [W-1:0]  hold, hold_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          hold_full, hold_full_nxt;
    logic          accept;
    logic          shifting;

    assign shifting = (state == SHIFT);
    // Ready depends only on the buffer flag, so a drain and an accept can never coincide.
    assign accept   = bus.load_valid && !hold_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sh        <= '0;
            hold      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_nxt;
            sh        <= sh_nxt;
            hold      <= hold_nxt;
            cnt       <= cnt_nxt;
            hold_full <= hold_full_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sh_nxt        = sh;
        hold_nxt      = hold;
        cnt_nxt       = cnt;
        hold_full_nxt = hold_full;
        case (state)
            IDLE: begin
                if (accept) begin
                    sh_nxt    = bus.load_data;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != LAST) begin
                    sh_nxt  = sh >> SYM_W;
                    cnt_nxt = cnt + CW'(1);
                    if (accept) begin
                        hold_nxt      = bus.load_data;
                        hold_full_nxt = 1'b1;
                    end
                end else if (hold_full) begin
                    sh_nxt        = hold;
                    hold_full_nxt = 1'b0;
                    cnt_nxt       = '0;
                end else if (accept) begin
                    // Bypass straight into the shifter on the last symbol: no idle cycle.
                    sh_nxt  = bus.load_data;
                    cnt_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    sh_nxt    = '0;
                end
            end
        endcase
    end

    assign bus.load_ready = !hold_full;
    assign bus.dataout    = shifting ? sh[SYM_W-1:0] : '0;
    assign bus.sym_valid  = shifting;
    assign bus.sof        = shifting && (cnt == '0);
    assign bus.eof        = shifting && (cnt == LAST);
    assign bus.busy       = shifting || hold_full;
endmodule

// File: tb/tb_shift_piso_tx.sv
// Self-checking bench for shift_piso_tx: vector table, directed multi-cycle sequences and
// random traffic, all compared against a symbol-queue reference model.
module tb_shift_piso_tx;
    localparam int SYM_W = 2;
    localparam int NSYM  = 4;
    localparam int W     = SYM_W * NSYM;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    shift_piso_tx_if #(.SYM_W(SYM_W), .NSYM(NSYM)) bus ();

    shift_piso_tx #(.SYM_W(SYM_W), .NSYM(NSYM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: every symbol still owed on dataout, in transmit order.
    typedef struct {
        logic [SYM_W-1:0] sym;
        int unsigned      k;
    } msym_t;
    msym_t mq[$];

    logic [SYM_W:0] log_q[$];   // {sym_valid, dataout} seen at each sample point
    logic [W-1:0]   dline;      // 4-stage delay line, newest symbol at the top

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_clear();
        mq.delete();
    endfunction

    function automatic void model_edge();
        bit acc;
        if (!reset_n) begin
            model_clear();
            return;
        end
        acc = bus.load_valid && (mq.size() <= NSYM);
        if (mq.size() > 0) void'(mq.pop_front());
        if (acc) begin
            for (int unsigned k = 0; k < NSYM; k++) begin
                msym_t e;
                e.sym = SYM_W'((bus.load_data / (1 << (SYM_W * k))) % (1 << SYM_W));
                e.k   = k;
                mq.push_back(e);
            end
        end
    endfunction

    function automatic void check_outputs();
        bit               v;
        logic [SYM_W-1:0] d;
        v = (mq.size() > 0);
        d = v ? mq[0].sym : '0;
        chk("dataout",    32'(bus.dataout),    32'(d));
        chk("sym_valid",  32'(bus.sym_valid),  32'(v));
        chk("sof",        32'(bus.sof),        32'(v && mq[0].k == 0));
        chk("eof",        32'(bus.eof),        32'(v && mq[0].k == NSYM - 1));
        chk("busy",       32'(bus.busy),       32'(v));
        chk("load_ready", 32'(bus.load_ready), 32'(mq.size() <= NSYM));
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        log_q.push_back({bus.sym_valid, bus.dataout});
        if (bus.sym_valid) dline = {bus.dataout, dline[W-1:SYM_W]};
    endtask

    task automatic check_stream(string name, input logic [SYM_W-1:0] e[$]);
        for (int i = 0; i < e.size(); i++) begin
            if (i < log_q.size())
                chk($sformatf("%s[%0d]", name, i), 32'(log_q[i]), 32'({1'b1, e[i]}));
            else
                chk($sformatf("%s[%0d] missing", name, i), 32'hFFFF_FFFF, 32'({1'b1, e[i]}));
        end
    endtask

    typedef struct {
        logic [W-1:0]     data;
        logic [SYM_W-1:0] s0, s1, s2, s3;
    } vec_t;

    initial begin
        vec_t tbl[6];
        logic [SYM_W-1:0] e[$];
        logic [W-1:0] words[3];
        int unsigned idx, stalls;
        int eof1, acc3;
        bit accepted;

        tbl[0] = '{8'hE4, 2'd0, 2'd1, 2'd2, 2'd3};
        tbl[1] = '{8'h1B, 2'd3, 2'd2, 2'd1, 2'd0};
        tbl[2] = '{8'h5A, 2'd2, 2'd2, 2'd1, 2'd1};
        tbl[3] = '{8'h00, 2'd0, 2'd0, 2'd0, 2'd0};
        tbl[4] = '{8'hFF, 2'd3, 2'd3, 2'd3, 2'd3};
        tbl[5] = '{8'hA5, 2'd1, 2'd1, 2'd2, 2'd2};

        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        dline          = '0;

        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();

        // Single words: symbol order, idle afterwards, loopback through the delay line.
        for (int i = 0; i < 6; i++) begin
            log_q.delete();
            bus.load_data  = tbl[i].data;
            bus.load_valid = 1'b1;
            tick();
            bus.load_valid = 1'b0;
            bus.load_data  = '0;
            repeat (NSYM - 1) tick();
            chk($sformatf("delay_line_%0h", tbl[i].data), 32'(dline), 32'(tbl[i].data));
            tick();
            e = '{tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3};
            check_stream($sformatf("word_%0h", tbl[i].data), e);
            chk("idle_after_word", 32'(log_q[NSYM]), 32'(0));
            repeat (2) tick();
        end

        // Back-to-back pair with load_valid held: 8 contiguous symbols.
        log_q.delete();
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hE4;
        tick();
        bus.load_data  = 8'h1B;
        tick();
        bus.load_valid = 1'b0;
        repeat (7) tick();
        e = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        check_stream("b2b", e);
        chk("b2b_idle", 32'(log_q[8]), 32'(0));
        repeat (2) tick();

        // Backpressure: three words offered continuously.
        words = '{8'hE4, 8'h1B, 8'h5A};
        idx = 0; stalls = 0; eof1 = -1; acc3 = -1;
        log_q.delete();
        for (int w = 0; w < 20; w++) begin
            bus.load_valid = (idx < 3);
            bus.load_data  = (idx < 3) ? words[idx] : '0;
            accepted = bus.load_valid && bus.load_ready;
            if (bus.load_valid && !bus.load_ready) stalls++;
            if (accepted && idx == 2) acc3 = w;
            tick();
            if (accepted) idx++;
            if (bus.eof && eof1 < 0) eof1 = w + 1;
        end
        e = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1};
        check_stream("bp", e);
        chk("bp_all_accepted", 32'(idx), 32'(3));
        chk("bp_stall_cycles", 32'(stalls), 32'(3));
        chk("bp_word3_after_eof1", 32'(acc3), 32'(eof1 + 1));

        // Reset mid-word with a buffered word: everything discarded at once.
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hE4;
        tick();
        bus.load_data  = 8'h1B;
        tick();
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        chk("pre_reset_busy", 32'(bus.busy), 32'(1));
        chk("pre_reset_sym1", 32'(bus.dataout), 32'(1));
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        check_outputs();
        tick();
        reset_n = 1'b1;
        log_q.delete();
        repeat (6) tick();
        for (int i = 0; i < 6; i++) chk("post_reset_idle", 32'(log_q[i]), 32'(0));
        log_q.delete();
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h5A;
        tick();
        bus.load_valid = 1'b0;
        repeat (NSYM) tick();
        e = '{2'd2, 2'd2, 2'd1, 2'd1};
        check_stream("after_reset_5A", e);

        // Random traffic, with one asynchronous reset in the middle.
        for (int c = 0; c < 400; c++) begin
            bus.load_valid = ($urandom_range(0, 9) < 6);
            bus.load_data  = W'($urandom);
            if (c == 200) begin
                #2 reset_n = 1'b0;
                #1;
                model_clear();
                check_outputs();
                tick();
                reset_n = 1'b1;
            end
            tick();
        end
        bus.load_valid = 1'b0;
        repeat (3 * NSYM) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
